dl_stream_demux4: RTL and testbench

Packet-aware 1-to-4 stream demultiplexer with a registered output slot per destination. It steers a single valid/ready input stream to one of four valid/ready output streams, selected by a 2-bit destination tag. The tag is latched on the first beat of a packet and held until the beat marked last, so a packet never splits across outputs. It is the distribution-side counterpart of the 4-to-1 mux in the muxes library, for fan-out points such as writeback and response routing.

---
 rtl/dl_stream_demux4.sv | 112 +++++++++++
 tb/tb_dl_stream_demux4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dl_stream_demux4.sv
// Packet-aware 1-to-4 valid/ready demultiplexer with one registered slot per destination.
// The destination tag is latched on a packet's head beat and held until its last beat.
module dl_stream_demux4 #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] out_data0,
  output logic [NUM_BITS-1:0] out_data1,
  output logic [NUM_BITS-1:0] out_data2,
  output logic [NUM_BITS-1:0] out_data3,
  output logic [3:0]          out_last,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic                pkt_active
);

  localparam int unsigned NUM_DEST = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lock_sel_q, lock_sel_d;
  logic [1:0]          dest;
  logic                acc;
  logic [NUM_DEST-1:0] full_q;
  logic [NUM_DEST-1:0] last_q;
  logic [NUM_BITS-1:0] data_q [NUM_DEST];

  // State and locked destination register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // Destination select, input handshake and next state
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    dest       = in_sel;
    in_ready   = 1'b0;
    acc        = 1'b0;

    case (state_q)
      IDLE:    dest = in_sel;
      LOCKED:  dest = lock_sel_q;
      default: dest = in_sel;
    endcase

    // A full slot still accepts when it is being drained in the same cycle
    in_ready = !rst && (!full_q[dest] || out_ready[dest]);
    acc      = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (acc && !in_last) begin
          state_d    = LOCKED;
          lock_sel_d = in_sel;
        end
      end
      LOCKED: begin
        if (acc && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-destination output slots; load takes priority over pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      last_q <= '0;
      for (int i = 0; i < NUM_DEST; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (acc && (dest == 2'(i))) begin
          data_q[i] <= in_data;
          last_q[i] <= in_last;
          full_q[i] <= 1'b1;
        end else if (full_q[i] && out_ready[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid  = full_q;
  assign out_last   = last_q;
  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign out_data3  = data_q[3];
  assign pkt_active = (state_q == LOCKED);

endmodule

// File: tb/tb_dl_stream_demux4.sv
// Randomized bench for dl_stream_demux4 against a queue-based packet routing model.
module tb_dl_stream_demux4;

  localparam int unsigned NUM_BITS = 32;

  typedef logic [NUM_BITS:0] beat_t;  // {last, data}

  logic                clk;
  logic                rst;
  logic [NUM_BITS-1:0] in_data;
  logic [1:0]          in_sel;
  logic                in_last;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]          out_last;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic                pkt_active;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-destination FIFO of beats and packet lock tracking
  beat_t      mq [4][$];
  logic       m_in_pkt;
  logic [1:0] m_lock;

  dl_stream_demux4 #(.NUM_BITS(NUM_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pkt_active (pkt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_BITS-1:0] out_data_at(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_in_pkt = 1'b0;
    m_lock   = 2'd0;
  endtask

  // One cycle: drive after the falling edge, check, then advance the model to the next rising edge
  task automatic step(input logic v, input logic [1:0] sel, input logic l,
                      input logic [NUM_BITS-1:0] d, input logic [3:0] ordy);
    logic [1:0] dst;
    logic       exp_rdy;
    logic       acc;
    @(negedge clk);
    in_valid  = v;
    in_sel    = sel;
    in_last   = l;
    in_data   = d;
    out_ready = ordy;
    #1;
    dst     = m_in_pkt ? m_lock : sel;
    exp_rdy = !((mq[dst].size() != 0) && !ordy[dst]);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("pkt_active", 64'(pkt_active), 64'(m_in_pkt));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(mq[i].size() != 0));
      if (mq[i].size() != 0) begin
        chk($sformatf("out_data%0d", i), 64'(out_data_at(i)), 64'(mq[i][0][NUM_BITS-1:0]));
        chk($sformatf("out_last%0d", i), 64'(out_last[i]), 64'(mq[i][0][NUM_BITS]));
      end
    end
    acc = v && exp_rdy;
    for (int i = 0; i < 4; i++) begin
      if ((mq[i].size() != 0) && ordy[i]) void'(mq[i].pop_front());
    end
    if (acc) begin
      mq[dst].push_back({l, d});
      if (!m_in_pkt && !l) begin
        m_in_pkt = 1'b1;
        m_lock   = sel;
      end else if (m_in_pkt && l) begin
        m_in_pkt = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(4'b0000));
    chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
    chk("rst_pkt_active", 64'(pkt_active), 64'(1'b0));
    chk("rst_out_last", 64'(out_last), 64'(4'b0000));
    chk("rst_out_data1", 64'(out_data1), 64'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = 2'd0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    model_clear();
    do_reset();

    // Single-beat routing to each destination
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 1'b1, 32'(32'hA0 + k), 4'hF);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);

    // Packet lock: tag changes after the head are ignored
    step(1'b1, 2'd2, 1'b0, 32'h11, 4'hF);
    step(1'b1, 2'd0, 1'b0, 32'h12, 4'hF);
    step(1'b1, 2'd3, 1'b0, 32'h13, 4'hF);
    step(1'b1, 2'd0, 1'b1, 32'h14, 4'hF);
    step(1'b0, 2'd1, 1'b0, 32'd0, 4'hF);
    step(1'b0, 2'd1, 1'b0, 32'd0, 4'hF);

    // Backpressure on dest 1, then pass-through refill
    step(1'b1, 2'd1, 1'b1, 32'h21, 4'b1101);
    step(1'b1, 2'd1, 1'b1, 32'h22, 4'b1101);
    step(1'b1, 2'd1, 1'b1, 32'h22, 4'b1101);
    step(1'b1, 2'd1, 1'b1, 32'h22, 4'hF);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);

    // Stalled slot 0 does not block dest 3
    step(1'b1, 2'd0, 1'b1, 32'h30, 4'b1110);
    step(1'b1, 2'd3, 1'b1, 32'h33, 4'b1110);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'b1110);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'b1110);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);

    // Reset in the middle of a packet with slot 1 full
    step(1'b1, 2'd1, 1'b0, 32'h41, 4'hF);
    step(1'b1, 2'd1, 1'b0, 32'h42, 4'b1101);
    step(1'b0, 2'd1, 1'b0, 32'd0, 4'b1101);
    do_reset();
    step(1'b1, 2'd3, 1'b1, 32'h55, 4'hF);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 1'b0, 32'd0, 4'hF);

    // Tag and last are ignored while in_valid is low
    for (int k = 0; k < 8; k++)
      step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 9) < 3), $urandom,
             4'({$urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
